// File: rtl/cpu_controller.sv
// Moore FSM sequencing one instruction at a time through the register-file/ALU datapath.
// Define CPU_CONTROLLER_ILLEGAL_TRAP_EN to lock up in a TRAP state on unsupported instructions.
module cpu_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [1:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_WAIT      = 4'd0,
    S_DECODE    = 4'd1,
    S_WRITE_IMM = 4'd2,
    S_GET_A     = 4'd3,
    S_GET_B     = 4'd4,
    S_ALU       = 4'd5,
    S_ALU_A0    = 4'd6,
    S_CMP       = 4'd7,
`ifdef CPU_CONTROLLER_ILLEGAL_TRAP_EN
    S_TRAP      = 4'd9,
`endif
    S_WRITE_REG = 4'd8
  } state_t;

  localparam logic [4:0] I_MOV_IMM = 5'b110_10;
  localparam logic [4:0] I_MOV_REG = 5'b110_00;
  localparam logic [4:0] I_ADD     = 5'b101_00;
  localparam logic [4:0] I_CMP     = 5'b101_01;
  localparam logic [4:0] I_AND     = 5'b101_10;
  localparam logic [4:0] I_MVN     = 5'b101_11;

  state_t     state;
  state_t     next_state;
  logic [4:0] instr;

  assign instr = {opcode, op};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_WAIT;
    else       state <= next_state;
  end

  // The A-input zeroing for MOV/MVN is resolved in GET_B so ALU outputs stay pure Moore.
  always_comb begin
    next_state = state;
    case (state)
      S_WAIT:      if (s) next_state = S_DECODE;
      S_DECODE: begin
        case (instr)
          I_MOV_IMM:             next_state = S_WRITE_IMM;
          I_MOV_REG, I_MVN:      next_state = S_GET_B;
          I_ADD, I_CMP, I_AND:   next_state = S_GET_A;
`ifdef CPU_CONTROLLER_ILLEGAL_TRAP_EN
          default:               next_state = S_TRAP;
`else
          default:               next_state = S_WAIT;
`endif
        endcase
      end
      S_WRITE_IMM: next_state = S_WAIT;
      S_GET_A:     next_state = S_GET_B;
      S_GET_B: begin
        if (instr == I_CMP)                           next_state = S_CMP;
        else if (instr == I_MOV_REG || instr == I_MVN) next_state = S_ALU_A0;
        else                                          next_state = S_ALU;
      end
      S_ALU:       next_state = S_WRITE_REG;
      S_ALU_A0:    next_state = S_WRITE_REG;
      S_CMP:       next_state = S_WAIT;
      S_WRITE_REG: next_state = S_WAIT;
`ifdef CPU_CONTROLLER_ILLEGAL_TRAP_EN
      S_TRAP:      next_state = S_TRAP;
`endif
      default:     next_state = S_WAIT;
    endcase
  end

  always_comb begin
    w       = 1'b0;
    nsel    = 2'b00;
    vsel    = 2'b00;
    loada   = 1'b0;
    loadb   = 1'b0;
    loadc   = 1'b0;
    loads   = 1'b0;
    asel    = 1'b0;
    bsel    = 1'b0;
    write   = 1'b0;
    illegal = 1'b0;
    case (state)
      S_WAIT:      w = 1'b1;
      S_WRITE_IMM: begin
        vsel  = 2'b01;
        write = 1'b1;
      end
      S_GET_A:     loada = 1'b1;
      S_GET_B: begin
        nsel  = 2'b10;
        loadb = 1'b1;
      end
      S_ALU:       loadc = 1'b1;
      S_ALU_A0: begin
        loadc = 1'b1;
        asel  = 1'b1;
      end
      S_CMP:       loads = 1'b1;
      S_WRITE_REG: begin
        nsel  = 2'b01;
        write = 1'b1;
      end
`ifdef CPU_CONTROLLER_ILLEGAL_TRAP_EN
      S_TRAP:      illegal = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Table-driven bench for cpu_controller: per-cycle vectors plus hand-written reset and trap sequences.
module tb_cpu_controller;

  logic       clk;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [1:0] nsel;
  logic [1:0] vsel;
  logic       loada, loadb, loadc, loads, asel, bsel, write, illegal;
  logic [12:0] dutOut;

  int checkCount = 0;
  int passCount  = 0;

  // Output bundle order: w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, illegal
  localparam logic [12:0] O_WAIT  = 13'b1_00_00_0000_00_0_0;
  localparam logic [12:0] O_DEC   = 13'b0_00_00_0000_00_0_0;
  localparam logic [12:0] O_WIMM  = 13'b0_00_01_0000_00_1_0;
  localparam logic [12:0] O_GETA  = 13'b0_00_00_1000_00_0_0;
  localparam logic [12:0] O_GETB  = 13'b0_10_00_0100_00_0_0;
  localparam logic [12:0] O_ALU   = 13'b0_00_00_0010_00_0_0;
  localparam logic [12:0] O_ALUA0 = 13'b0_00_00_0010_10_0_0;
  localparam logic [12:0] O_CMP   = 13'b0_00_00_0001_00_0_0;
  localparam logic [12:0] O_WREG  = 13'b0_01_00_0000_00_1_0;
  localparam logic [12:0] O_TRAP  = 13'b0_00_00_0000_00_0_1;

  typedef struct {
    string       name;
    logic        sv;
    logic [2:0]  oc;
    logic [1:0]  o;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  cpu_controller dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .write(write), .illegal(illegal)
  );

  assign dutOut = {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input string name, input logic sv, input logic [2:0] oc,
                        input logic [1:0] o, input logic [12:0] exp);
    vec_t v;
    v.name = name; v.sv = sv; v.oc = oc; v.o = o; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic sv, input logic [2:0] oc, input logic [1:0] o);
    s      = sv;
    opcode = oc;
    op     = o;
  endtask

  task automatic checkOutput(input string name, input logic [12:0] exp);
    checkCount++;
    if (dutOut === exp) passCount++;
    else $display("[TB] FAIL %s: got %b expected %b (w nsel vsel la lb lc ls as bs wr il)",
                  name, dutOut, exp);
  endtask

  task automatic stepCheck(input string name, input logic [12:0] exp);
    @(posedge clk);
    #1;
    checkOutput(name, exp);
  endtask

  initial begin
    // MOV Rn,#imm8 with a one-cycle start pulse
    addVec("movimm_dec",   1, 3'b110, 2'b10, O_DEC);
    addVec("movimm_write", 0, 3'b110, 2'b10, O_WIMM);
    addVec("movimm_wait",  0, 3'b110, 2'b10, O_WAIT);
    addVec("idle_stay",    0, 3'b110, 2'b10, O_WAIT);
    // ADD with s held high throughout: s must be ignored outside WAIT
    addVec("add_dec",      1, 3'b101, 2'b00, O_DEC);
    addVec("add_geta",     1, 3'b101, 2'b00, O_GETA);
    addVec("add_getb",     1, 3'b101, 2'b00, O_GETB);
    addVec("add_alu",      1, 3'b101, 2'b00, O_ALU);
    addVec("add_wreg",     1, 3'b101, 2'b00, O_WREG);
    addVec("add_wait",     0, 3'b101, 2'b00, O_WAIT);
    // CMP
    addVec("cmp_dec",      1, 3'b101, 2'b01, O_DEC);
    addVec("cmp_geta",     0, 3'b101, 2'b01, O_GETA);
    addVec("cmp_getb",     0, 3'b101, 2'b01, O_GETB);
    addVec("cmp_loads",    0, 3'b101, 2'b01, O_CMP);
    addVec("cmp_wait",     0, 3'b101, 2'b01, O_WAIT);
    // MOV Rd,Rm
    addVec("movreg_dec",   1, 3'b110, 2'b00, O_DEC);
    addVec("movreg_getb",  0, 3'b110, 2'b00, O_GETB);
    addVec("movreg_alu",   0, 3'b110, 2'b00, O_ALUA0);
    addVec("movreg_wreg",  0, 3'b110, 2'b00, O_WREG);
    addVec("movreg_wait",  0, 3'b110, 2'b00, O_WAIT);
    // MVN
    addVec("mvn_dec",      1, 3'b101, 2'b11, O_DEC);
    addVec("mvn_getb",     0, 3'b101, 2'b11, O_GETB);
    addVec("mvn_alu",      0, 3'b101, 2'b11, O_ALUA0);
    addVec("mvn_wreg",     0, 3'b101, 2'b11, O_WREG);
    addVec("mvn_wait",     0, 3'b101, 2'b11, O_WAIT);
    // AND
    addVec("and_dec",      1, 3'b101, 2'b10, O_DEC);
    addVec("and_geta",     0, 3'b101, 2'b10, O_GETA);
    addVec("and_getb",     0, 3'b101, 2'b10, O_GETB);
    addVec("and_alu",      0, 3'b101, 2'b10, O_ALU);
    addVec("and_wreg",     0, 3'b101, 2'b10, O_WREG);
    addVec("and_wait",     0, 3'b101, 2'b10, O_WAIT);
    // Back-to-back MOV imm with s held: w high for exactly one cycle
    addVec("b2b_dec1",     1, 3'b110, 2'b10, O_DEC);
    addVec("b2b_write1",   1, 3'b110, 2'b10, O_WIMM);
    addVec("b2b_wait",     1, 3'b110, 2'b10, O_WAIT);
    addVec("b2b_dec2",     1, 3'b110, 2'b10, O_DEC);
    addVec("b2b_write2",   0, 3'b110, 2'b10, O_WIMM);
    addVec("b2b_wait2",    0, 3'b110, 2'b10, O_WAIT);
`ifndef CPU_CONTROLLER_ILLEGAL_TRAP_EN
    // Unsupported instruction returns to WAIT with no enables
    addVec("illegal_dec",  1, 3'b111, 2'b00, O_DEC);
    addVec("illegal_wait", 0, 3'b111, 2'b00, O_WAIT);
    addVec("illegal_idle", 0, 3'b111, 2'b00, O_WAIT);
`endif

    reset = 1'b1;
    applyStimulus(0, 3'b000, 2'b00);
    #12;
    checkOutput("reset_state", O_WAIT);
    reset = 1'b0;
    stepCheck("post_reset_idle", O_WAIT);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sv, vecs[i].oc, vecs[i].o);
      stepCheck(vecs[i].name, vecs[i].exp);
    end

    // Asynchronous reset in GET_B of an ADD must drop loadb and return to WAIT mid-cycle
    applyStimulus(1, 3'b101, 2'b00);
    stepCheck("rst_add_dec", O_DEC);
    applyStimulus(0, 3'b101, 2'b00);
    stepCheck("rst_add_geta", O_GETA);
    stepCheck("rst_add_getb", O_GETB);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_midinstr", O_WAIT);
    #2;
    reset = 1'b0;
    stepCheck("after_reset_stay", O_WAIT);

`ifdef CPU_CONTROLLER_ILLEGAL_TRAP_EN
    applyStimulus(1, 3'b111, 2'b00);
    stepCheck("trap_dec", O_DEC);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i[0], 3'b111, 2'b00);
      stepCheck($sformatf("trap_hold_%0d", i), O_TRAP);
    end
    reset = 1'b1;
    #1;
    checkOutput("trap_cleared_by_reset", O_WAIT);
    #2;
    reset = 1'b0;
    applyStimulus(0, 3'b000, 2'b00);
    stepCheck("trap_after_reset", O_WAIT);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Moore FSM that sequences one instruction at a time through the register-file/ALU datapath.
- Sits directly downstream of the instruction decoder:
  - consumes the decoder's opcode/op fields;
  - drives back the decoder's 2-bit nsel register selector;
  - drives all datapath load/write/mux controls.
- Handshake with the surrounding CPU: `s` (start) and `w` (waiting/idle).

Parameters:
- None. State encoding is internal; 4-bit state register.

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- s  input  1  start request; sampled only in WAIT
- opcode  input  3  instruction class from decoder (C[15:13])
- op  input  2  sub-operation from decoder (C[12:11])
- w  output  1  1 = idle in WAIT, ready for new instruction
- nsel  output  2  register selector to decoder: 00=Rn, 01=Rd, 1x=Rm
- vsel  output  2  write-back mux: 00=datapath C, 01=sximm8, 10/11 reserved (never driven)
- loada  output  1  load A register
- loadb  output  1  load B register
- loadc  output  1  load C register
- loads  output  1  load status flags
- asel  output  1  1 = force ALU A input to 0
- bsel  output  1  1 = ALU B input from sximm5
- write  output  1  register-file write enable
- illegal  output  1  unsupported opcode/op seen (see Optional Feature)

Behaviour:
- Reset (async, active-high): state=WAIT immediately, no clock needed. Outputs: w=1, all enables 0, nsel=00, vsel=00, asel=0, bsel=0, illegal=0.
- Reset mid-instruction: write/load deassert asynchronously; no partial write-back completes.
- All outputs are Moore, decoded from the state register only. Per state, unlisted outputs are 0/00.
- WAIT: w=1. If s=1 at the edge, go to DECODE; else stay.
- DECODE: all outputs idle. Next state from {opcode,op}:
  - 110_10 MOV Rn,#imm8 → WRITE_IMM
  - 110_00 MOV Rd,Rm{,sh} → GET_B
  - 101_00 ADD → GET_A
  - 101_01 CMP → GET_A
  - 101_10 AND → GET_A
  - 101_11 MVN → GET_B
  - anything else → ILLEGAL handling (see Optional Feature)
- WRITE_IMM: nsel=00, vsel=01, write=1 → WAIT.
- GET_A: nsel=00, loada=1 → GET_B.
- GET_B: nsel=10, loadb=1. Next state: CMP → CMP_ST; otherwise → ALU.
- ALU: loadc=1; asel=1 for MOV and MVN, else 0; bsel=0 → WRITE_REG.
- CMP_ST: loads=1, asel=0, bsel=0 → WAIT. No register write.
- WRITE_REG: nsel=01, vsel=00, write=1 → WAIT.
- Latency, counted from the edge that samples s=1 to the first cycle with w=1 again:
  - MOV imm: 3 cycles
  - MVN / MOV reg: 5 cycles
  - CMP: 5 cycles
  - ADD / AND: 6 cycles
- s is ignored outside WAIT.
- If s is held high continuously, a new instruction starts on the edge after WAIT is entered; w is high for exactly one cycle.
- opcode/op must be stable from the DECODE cycle until WAIT. The controller only reads them in DECODE and GET_B.
- write and loads never assert in the same cycle. Exactly one of loada/loadb/loadc/loads/write is high, or none.

Optional Feature:
- Macro: CPU_CONTROLLER_ILLEGAL_TRAP_EN
- Defined:
  - Unsupported {opcode,op} in DECODE → TRAP state.
  - TRAP: all enables 0, w=0, illegal=1.
  - TRAP is held until reset; s is ignored.
- Undefined:
  - Unsupported {opcode,op} in DECODE → WAIT next cycle; no datapath effect.
  - illegal tied to 0.
  - TRAP state absent from RTL.

Test Plan:
- Reset during GET_B of an ADD (loadb=1) → in the same cycle: write=0, loadb=0, w=1, nsel=00. First post-reset edge with s=0 stays in WAIT.
- opcode=110, op=10, pulse s for one cycle → DECODE, then WRITE_IMM (nsel=00, vsel=01, write=1), then w=1 on the 3rd cycle after the sampling edge.
- opcode=101, op=00, s=1 → cycle-by-cycle sequence:
  - loada with nsel=00
  - loadb with nsel=10
  - loadc with asel=0, bsel=0
  - write with nsel=01, vsel=00
  - then w=1 on cycle 6
- opcode=101, op=01 (CMP) → loada, loadb, then loads=1 for exactly one cycle; write stays 0 throughout; w=1 on cycle 5.
- opcode=110, op=00 and then opcode=101, op=11 → GET_B then ALU with asel=1, loada never asserted, write with nsel=01.
- opcode=111, op=00, s=1:
  - with macro: illegal=1, w=0, held for 20 cycles with s toggling; cleared only by reset.
  - without macro: w=1 two cycles after the sampling edge, no enable ever high.
